// File: rtl/yuv422_pkg.sv
// ============================================================================
// yuv422_pkg : shared types and constants for the UYVY 4:2:2 byte packer
// Rev 1.0
// ============================================================================
`default_nettype none

package yuv422_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  // Byte-lane index of each component inside the packed UYVY word.
  localparam int LANE_U  = 3;
  localparam int LANE_Y0 = 2;
  localparam int LANE_V  = 1;
  localparam int LANE_Y1 = 0;

  typedef enum logic [1:0] {
    PH_U  = 2'd0,
    PH_Y0 = 2'd1,
    PH_V  = 2'd2,
    PH_Y1 = 2'd3
  } phase_e;

  // Two's-complement chroma to offset-binary (+128 mod 256).
  function automatic logic [BYTE_W-1:0] chroma_offset(input logic [BYTE_W-1:0] b);
    return {~b[BYTE_W-1], b[BYTE_W-2:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/yuv422_packer_if.sv
// ============================================================================
// yuv422_packer_if : byte-stream input and word-output handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface yuv422_packer_if #(
  parameter int FIFO_DEPTH = 8
) ();
  import yuv422_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                in_valid;
  logic [BYTE_W-1:0]   yuv_in;
  logic                flush;
  logic                word_valid;
  logic                word_ready;
  logic [WORD_W-1:0]   word_data;
  logic [LVL_W-1:0]    fifo_level;
  logic                almost_full;
  logic                overflow;
  logic [15:0]         pair_cnt;

  // master: upstream byte source plus downstream word consumer
  modport master (
    output in_valid, yuv_in, flush, word_ready,
    input  word_valid, word_data, fifo_level, almost_full, overflow, pair_cnt
  );

  // slave: the packer itself
  modport slave (
    input  in_valid, yuv_in, flush, word_ready,
    output word_valid, word_data, fifo_level, almost_full, overflow, pair_cnt
  );

endinterface

`default_nettype wire

// File: rtl/yuv422_word_fifo.sv
// ============================================================================
// yuv422_word_fifo : synchronous FIFO with push/pop, level and full/empty flags
// Rev 1.0
// ============================================================================
`default_nettype none

module yuv422_word_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] pop_data,
  output logic      [LVL_W-1:0] level,
  output logic      [LVL_W-1:0] level_next,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pop_ok;
  logic             push_ok;

  always_comb begin
    full     = (level_q == LVL_W'(DEPTH));
    empty    = (level_q == '0);
    pop_ok   = pop && !empty;
    // When full, a simultaneous pop frees the slot the push writes into.
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign pop_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign level      = level_q;
  assign level_next = level_d;

endmodule

`default_nettype wire

// File: rtl/yuv422_packer.sv
// ============================================================================
// yuv422_packer : packs the U,Y0,V,Y1 byte stream into UYVY words and buffers
//                 them behind a valid/ready FIFO. Option: YUV422_CHROMA_OFFSET_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module yuv422_packer
  import yuv422_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = 6
) (
  input  wire logic        clk,
  input  wire logic        reset,
  yuv422_packer_if.slave   bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  phase_e              phase_q, phase_d;
  logic [BYTE_W-1:0]   u_q, u_d;
  logic [BYTE_W-1:0]   y0_q, y0_d;
  logic [BYTE_W-1:0]   v_q, v_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         pair_cnt_q, pair_cnt_d;
  logic                almost_full_q, almost_full_d;

  logic [BYTE_W-1:0]   chroma_byte;
  logic                push;
  logic [WORD_W-1:0]   push_word;
  logic [WORD_W-1:0]   fifo_pop_data;
  logic [LVL_W-1:0]    fifo_level;
  logic [LVL_W-1:0]    fifo_level_next;
  logic                fifo_full;
  logic                fifo_empty;

`ifdef YUV422_CHROMA_OFFSET_EN
  assign chroma_byte = chroma_offset(bus.yuv_in);
`else
  assign chroma_byte = bus.yuv_in;
`endif

  always_comb begin
    phase_d = phase_q;
    u_d     = u_q;
    y0_d    = y0_q;
    v_d     = v_q;
    push    = 1'b0;
    // flush has priority over a coincident byte strobe
    if (bus.flush) begin
      phase_d = PH_U;
      u_d     = '0;
      y0_d    = '0;
      v_d     = '0;
    end else if (bus.in_valid) begin
      case (phase_q)
        PH_U:    begin u_d  = chroma_byte; phase_d = PH_Y0; end
        PH_Y0:   begin y0_d = bus.yuv_in;  phase_d = PH_V;  end
        PH_V:    begin v_d  = chroma_byte; phase_d = PH_Y1; end
        PH_Y1:   begin push = 1'b1;        phase_d = PH_U;  end
        default: phase_d = PH_U;
      endcase
    end

    push_word                           = '0;
    push_word[LANE_U*BYTE_W  +: BYTE_W] = u_q;
    push_word[LANE_Y0*BYTE_W +: BYTE_W] = y0_q;
    push_word[LANE_V*BYTE_W  +: BYTE_W] = v_q;
    push_word[LANE_Y1*BYTE_W +: BYTE_W] = bus.yuv_in;

    // A full FIFO only drops the word when no pop frees a slot this edge.
    overflow_d    = overflow_q | (push && fifo_full && !bus.word_ready);
    pair_cnt_d    = pair_cnt_q + 16'(push);
    almost_full_d = (fifo_level_next >= LVL_W'(AF_THRESH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= PH_U;
      u_q           <= '0;
      y0_q          <= '0;
      v_q           <= '0;
      overflow_q    <= 1'b0;
      pair_cnt_q    <= '0;
      almost_full_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      u_q           <= u_d;
      y0_q          <= y0_d;
      v_q           <= v_d;
      overflow_q    <= overflow_d;
      pair_cnt_q    <= pair_cnt_d;
      almost_full_q <= almost_full_d;
    end
  end

  yuv422_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_word),
    .pop        (bus.word_ready),
    .pop_data   (fifo_pop_data),
    .level      (fifo_level),
    .level_next (fifo_level_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign bus.word_valid  = !fifo_empty;
  assign bus.word_data   = fifo_pop_data;
  assign bus.fifo_level  = fifo_level;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;
  assign bus.pair_cnt    = pair_cnt_q;

endmodule

`default_nettype wire
